// File: rtl/dualmem_req_bridge.sv
// dualmem_req_bridge
//   Valid/ready front end for one port of the 64-bit x 2048-word dual-port BRAM.
//   Byte-addressed requests become a word address plus per-byte enables for the
//   RAM. Read data (registered inside the RAM) goes into a 2-entry response
//   FIFO so the master can stall. Accesses outside the window get an error
//   response and do not touch the RAM.
//
//   Build option: DUALMEM_BRIDGE_WRITE_RSP_EN
//     defined   - every accepted write produces a response (rdata=0).
//     undefined - in-window writes are posted: no response, no credit used.
//                 Out-of-window writes still produce an err=1 response.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_addr,          request: write flag, byte address,
//   req_wdata, req_be          write data and byte strobes
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         response data (0 for writes/errors), error flag
//   mem_en, mem_we             RAM per-byte enable and write enable
//   mem_addr, mem_wdata        RAM word address and write data
//   mem_rdata                  RAM read data, valid one cycle after a read

module dualmem_req_bridge #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       WIN_BYTES = 16384
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        mem_en,
    output logic [7:0]        mem_we,
    output logic [10:0]       mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

`ifdef DUALMEM_BRIDGE_WRITE_RSP_EN
    localparam logic WriteRsp = 1'b1;
`else
    localparam logic WriteRsp = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] WinLimit = ADDR_W'(WIN_BYTES);

    logic [ADDR_W-1:0] diff;
    logic              in_win;
    logic              accept;
    logic              needs_rsp;
    logic              push;
    logic              pop;
    logic [2:0]        owed;
    logic [63:0]       push_data;

    // Response slot for the request accepted last cycle.
    logic              inflight_q;
    logic              pend_err_q;
    logic              pend_rd_q;

    // Held RAM address/data while no request is accepted.
    logic [10:0]       addr_q;
    logic [63:0]       wdata_q;

    logic [63:0]       fifo_data_q [2];
    logic              fifo_err_q  [2];
    logic              wptr_q;
    logic              rptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    // Modulo subtraction: addresses below BASE_ADDR wrap high and fail the compare.
    assign diff      = req_addr - BASE_ADDR;
    assign in_win    = diff < WinLimit;
    assign needs_rsp = ~req_we | ~in_win | WriteRsp;

    assign push = inflight_q;
    assign pop  = rsp_valid & rsp_ready;

    // Credits owed after this cycle's pop. Counting the pop keeps a full
    // 1/cycle stream flowing; the FIFO still never sees a push when full.
    always_comb begin
        owed = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    end

    assign req_ready = rstn & (owed < 3'd2);
    assign accept    = req_valid & req_ready;

    always_comb begin
        mem_en    = '0;
        mem_we    = '0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (accept) begin
            mem_addr = diff[13:3];
            if (req_we) begin
                mem_wdata = req_wdata;
            end
            if (in_win) begin
                if (req_we) begin
                    mem_en = req_be;
                    mem_we = req_be;
                end else begin
                    mem_en = 8'hFF;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
            pend_err_q <= 1'b0;
            pend_rd_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            inflight_q <= accept & needs_rsp;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            if (accept) begin
                pend_err_q <= ~in_win;
                pend_rd_q  <= ~req_we & in_win;
            end
        end
    end

    // Only in-window reads take RAM data; writes and errors return zero.
    assign push_data = pend_rd_q ? mem_rdata : '0;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_err_q[0]  <= 1'b0;
            fifo_err_q[1]  <= 1'b0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            count_q        <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wptr_q] <= push_data;
                fifo_err_q[wptr_q]  <= pend_err_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_d;
        end
    end

    assign rsp_valid = (count_q != 2'd0);
    assign rsp_rdata = rsp_valid ? fifo_data_q[rptr_q] : '0;
    assign rsp_err   = rsp_valid & fifo_err_q[rptr_q];

endmodule

// File: tb/tb_dualmem_req_bridge.sv
// Directed bench for dualmem_req_bridge with a behavioural byte-enabled RAM.
// Inputs are driven and outputs sampled at the falling clock edge.

module tb_dualmem_req_bridge;

`ifdef DUALMEM_BRIDGE_WRITE_RSP_EN
    localparam logic WRSP = 1'b1;
`else
    localparam logic WRSP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  mem_en;
    logic [7:0]  mem_we;
    logic [10:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] ram [2048];
    logic [63:0] exp_stream [16];

    localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] D5 = 64'hDEAD_BEEF_0BAD_F00D;

    dualmem_req_bridge dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM port: registered read, per-byte write.
    always @(posedge clk) begin
        if (|mem_en) mem_rdata <= ram[mem_addr];
        for (int i = 0; i < 8; i++) begin
            if (mem_en[i] && mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [7:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = '0;
        ram[5] = D5;
        for (int i = 0; i < 16; i++) begin
            exp_stream[i] = {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
            ram[64 + i]   = exp_stream[i];
        end
        mem_rdata = '0;
        rstn      = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rstn = 1'b1;
        #1 check("post_rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);

        // Full write then read-back at 0x18
        rsp_ready = 1'b1;
        drive(1'b1, 32'h18, D1, 8'hFF);
        #1;
        check("wr1_mem_addr", 64'(mem_addr), 64'd3);
        check("wr1_mem_en", 64'(mem_en), 64'hFF);
        check("wr1_mem_we", 64'(mem_we), 64'hFF);
        check("wr1_mem_wdata", mem_wdata, D1);
        @(negedge clk);
        idle();
        #1;
        check("idle_mem_en", 64'(mem_en), 64'd0);
        check("idle_mem_we", 64'(mem_we), 64'd0);
        check("idle_mem_addr_hold", 64'(mem_addr), 64'd3);
        check("idle_mem_wdata_hold", mem_wdata, D1);
        repeat (3) @(negedge clk);
        drive(1'b0, 32'h18, '0, 8'h00);
        #1;
        check("rd1_mem_en", 64'(mem_en), 64'hFF);
        check("rd1_mem_we", 64'(mem_we), 64'd0);
        check("rd1_mem_addr", 64'(mem_addr), 64'd3);
        @(negedge clk);
        idle();
        check("rd1_not_yet", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("rd1_valid", 64'(rsp_valid), 64'd1);
        check("rd1_rdata", rsp_rdata, D1);
        check("rd1_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        check("rd1_drained", 64'(rsp_valid), 64'd0);

        // Partial write (low 4 bytes) over word 4 holding 0
        drive(1'b1, 32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        #1;
        check("wr2_mem_we", 64'(mem_we), 64'h0F);
        check("wr2_mem_en", 64'(mem_en), 64'h0F);
        check("wr2_mem_addr", 64'(mem_addr), 64'd4);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        drive(1'b0, 32'h20, '0, 8'h00);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("rd2_valid", 64'(rsp_valid), 64'd1);
        check("rd2_rdata", rsp_rdata, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);

        // Last word of the window, low address bits ignored
        drive(1'b0, 32'h3FFF, '0, 8'h00);
        #1;
        check("last_mem_addr", 64'(mem_addr), 64'h7FF);
        check("last_mem_en", 64'(mem_en), 64'hFF);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("last_valid", 64'(rsp_valid), 64'd1);
        check("last_err", 64'(rsp_err), 64'd0);
        @(negedge clk);

        // Out-of-window read queued behind a pending in-window read
        rsp_ready = 1'b0;
        drive(1'b0, 32'h18, '0, 8'h00);
        @(negedge clk);
        drive(1'b0, 32'h4000, '0, 8'h00);
        #1;
        check("oow_mem_en", 64'(mem_en), 64'd0);
        check("oow_mem_we", 64'(mem_we), 64'd0);
        check("oow_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        idle();
        check("oow_credit_full", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("oow_first_valid", 64'(rsp_valid), 64'd1);
        check("oow_first_rdata", rsp_rdata, D1);
        check("oow_first_err", 64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("oow_second_valid", 64'(rsp_valid), 64'd1);
        check("oow_second_err", 64'(rsp_err), 64'd1);
        check("oow_second_rdata", rsp_rdata, 64'd0);
        @(negedge clk);
        check("oow_drained", 64'(rsp_valid), 64'd0);

        // Three back-to-back reads with the response side stalled
        rsp_ready = 1'b0;
        drive(1'b0, 32'h18, '0, 8'h00);
        #1 check("bp_rdy0", 64'(req_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h20, '0, 8'h00);
        #1 check("bp_rdy1", 64'(req_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h28, '0, 8'h00);
        #1 check("bp_rdy2_blocked", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("bp_hold_rdy", 64'(req_ready), 64'd0);
        check("bp_hold_data_a", rsp_rdata, D1);
        @(negedge clk);
        check("bp_stable_valid", 64'(rsp_valid), 64'd1);
        check("bp_stable_data", rsp_rdata, D1);
        check("bp_stable_err", 64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        #1 check("bp_rdy_on_pop", 64'(req_ready), 64'd1);
        @(negedge clk);
        idle();
        check("bp_second", rsp_rdata, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        check("bp_third_valid", 64'(rsp_valid), 64'd1);
        check("bp_third", rsp_rdata, D5);
        @(negedge clk);
        check("bp_drained", 64'(rsp_valid), 64'd0);

        // 16-read stream at full rate
        for (int k = 0; k < 18; k++) begin
            if (k >= 2) begin
                check($sformatf("stream_valid_%0d", k - 2), 64'(rsp_valid), 64'd1);
                check($sformatf("stream_data_%0d", k - 2), rsp_rdata, exp_stream[k - 2]);
            end
            if (k < 16) begin
                drive(1'b0, 32'((64 + k) * 8), '0, 8'h00);
                #1 check($sformatf("stream_ready_%0d", k), 64'(req_ready), 64'd1);
            end else begin
                idle();
            end
            @(negedge clk);
        end
        check("stream_drained", 64'(rsp_valid), 64'd0);

        // Reset with two responses owed
        rsp_ready = 1'b0;
        drive(1'b0, 32'h200, '0, 8'h00);
        @(negedge clk);
        drive(1'b0, 32'h208, '0, 8'h00);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("pre_rst_pending", 64'(rsp_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("no_stale_%0d", k), 64'(rsp_valid), 64'd0);
        end

        // In-window write: response only in the write-response build
        drive(1'b1, 32'h30, 64'h5555_AAAA_5555_AAAA, 8'hFF);
        #1 check("wr3_mem_we", 64'(mem_we), 64'hFF);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("wr3_rsp_valid", 64'(rsp_valid), 64'(WRSP));
        check("wr3_rsp_err", 64'(rsp_err), 64'd0);
        check("wr3_rsp_rdata", rsp_rdata, 64'd0);
        @(negedge clk);

        // Out-of-window write always answers with an error
        drive(1'b1, 32'h8000, 64'hFFFF_0000_FFFF_0000, 8'hFF);
        #1;
        check("wr4_mem_en", 64'(mem_en), 64'd0);
        check("wr4_mem_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("wr4_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr4_rsp_err", 64'(rsp_err), 64'd1);
        check("wr4_rsp_rdata", rsp_rdata, 64'd0);
        @(negedge clk);
        check("wr4_drained", 64'(rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
